// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and helpers.
//   REG_ADDR_W - register address width (x0..x31)
//   XLEN       - data width
//   NUM_REGS   - architectural register count
//   reg_addr_t / xlen_t / reg_mask_t - common typedefs
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot decode of a register address into a scoreboard bit vector.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_onehot = reg_mask_t'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request bundle, one lane per requester.
//   req_valid[i] - requester i has a write pending (addr/data held until ready)
//   req_ready[i] - grant to requester i, combinational from the arbiter
//   req_addr[i]  - destination register of requester i
//   req_data[i]  - write data of requester i
// master: requester side; slave: arbiter side.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic      [NUM_REQ-1:0] req_valid;
  logic      [NUM_REQ-1:0] req_ready;
  reg_addr_t [NUM_REQ-1:0] req_addr;
  xlen_t     [NUM_REQ-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       - request vector (N bits)
//   ptr       - index with highest priority this cycle (must be < N)
//   grant     - one-hot grant, zero when nothing requests
//   grant_idx - binary index of the granted requester
//   grant_any - some requester was granted
// The priority pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan upward from ptr with wrap; the first requester found wins.
  always_comb begin
    int   cand_s;
    logic hit_s;
    cand_s    = 0;
    hit_s     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s           = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      hit_s            = !grant_any && req[cand_s];
      grant[cand_s]    = grant[cand_s] | hit_s;
      grant_idx        = hit_s ? IDX_W'(cand_s) : grant_idx;
      grant_any        = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between NUM_REQ
// writeback requesters and tracks outstanding destination registers.
//   clk, rst     - clock / asynchronous active-high reset
//   req_bus      - writeback requests (slave side of regfile_wb_arbiter_if)
//   rsv_valid    - issue stage reserves rsv_addr as an outstanding destination
//   rsv_addr     - register being reserved
//   flush        - clear the whole pending-write scoreboard
//   pending_mask - bit r set while a write to xr is outstanding (bit 0 always 0)
//   wr_ena/wr_addr/wr_data - registered register-file write port, latency 1
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_wb_arbiter_if.slave          req_bus,
  input  logic                         rsv_valid,
  input  reg_addr_t                    rsv_addr,
  input  logic                         flush,
  output reg_mask_t                    pending_mask,
  output logic                         wr_ena,
  output reg_addr_t                    wr_addr,
  output xlen_t                        wr_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   ptr_next_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  reg_addr_t          sel_addr_s;
  xlen_t              sel_data_s;
  logic               commit_s;
  reg_mask_t          set_vec_s;
  reg_mask_t          clr_vec_s;
  reg_mask_t          mask_next_s;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_bus.req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Grant is a transfer: the arbiter only grants valid requesters.
  assign req_bus.req_ready = grant_s;

  assign sel_addr_s = req_bus.req_addr[grant_idx_s];
  assign sel_data_s = req_bus.req_data[grant_idx_s];

  // Writes to x0 are accepted from the requester but never reach the register file.
  assign commit_s = grant_any_s && (sel_addr_s != 5'd0);

  assign ptr_next_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (grant_idx_s + IDX_W'(1));

  // Set is applied after clear so a same-register reserve keeps the newer producer
  // outstanding; flush beats both; bit 0 is forced low.
  assign set_vec_s   = (rsv_valid && (rsv_addr != 5'd0)) ? reg_onehot(rsv_addr) : '0;
  assign clr_vec_s   = commit_s ? reg_onehot(sel_addr_s) : '0;
  assign mask_next_s = flush ? '0 : (((pending_mask & ~clr_vec_s) | set_vec_s) & ~reg_mask_t'(1));

  // Round-robin pointer, write-port output register and scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r        <= '0;
      wr_ena       <= 1'b0;
      wr_addr      <= 5'd0;
      wr_data      <= 32'd0;
      pending_mask <= '0;
    end else begin
      if (grant_any_s) begin
        ptr_r <= ptr_next_s;
      end else begin
        ptr_r <= ptr_r;
      end
      wr_ena <= commit_s;
      if (commit_s) begin
        wr_addr <= sel_addr_s;
        wr_data <= sel_data_s;
      end else begin
        wr_addr <= wr_addr;
        wr_data <= wr_data;
      end
      pending_mask <= mask_next_s;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NR = 2;

  typedef struct packed {
    reg_addr_t addr;
    xlen_t     data;
  } wr_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      rsv_valid;
  reg_addr_t rsv_addr;
  logic      flush;
  reg_mask_t pending_mask;
  logic      wr_ena;
  reg_addr_t wr_addr;
  xlen_t     wr_data;

  int checks   = 0;
  int failures = 0;

  wr_t exp_q[$];
  int  model_ptr = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_bus      (bus),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .flush        (flush),
    .pending_mask (pending_mask),
    .wr_ena       (wr_ena),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: reference round-robin model predicts grants on each negedge,
  // pushes the expected write, and pops it against the output one cycle later.
  initial begin : monitor
    wr_t              e;
    logic [NR-1:0]    exp_rdy;
    int               eg;
    int               c;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_ptr = 0;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          if (wr_ena !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle: wr_ena=%b expected 0", wr_ena);
          end
        end else begin
          e = exp_q.pop_front();
          if (wr_ena !== 1'b1 || wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL wr_out: ena=%b addr=%0d data=%h expected ena=1 addr=%0d data=%h",
                     wr_ena, wr_addr, wr_data, e.addr, e.data);
          end
        end
        eg = -1;
        for (int k = 0; k < NR; k++) begin
          c = (model_ptr + k) % NR;
          if (eg < 0 && bus.req_valid[c] === 1'b1) eg = c;
        end
        exp_rdy = '0;
        if (eg >= 0) exp_rdy[eg] = 1'b1;
        checks++;
        if (bus.req_ready !== exp_rdy) begin
          failures++;
          $display("FAIL ready_model: req_ready=%b expected %b", bus.req_ready, exp_rdy);
        end
        if (eg >= 0) begin
          if (bus.req_addr[eg] != 5'd0) begin
            e.addr = bus.req_addr[eg];
            e.data = bus.req_data[eg];
            exp_q.push_back(e);
          end
          model_ptr = (eg + 1) % NR;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rsv_valid     = 1'b0;
    rsv_addr      = 5'd0;
    flush         = 1'b0;
  endtask

  task automatic check_mask(input string name, input reg_mask_t exp);
    checks++;
    if (pending_mask !== exp) begin
      failures++;
      $display("FAIL %s: pending_mask=%h expected %h", name, pending_mask, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (wr_ena !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 ||
        pending_mask !== 32'd0 || bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset: ena=%b addr=%0d data=%h mask=%h ready=%b expected all 0",
               wr_ena, wr_addr, wr_data, pending_mask, bus.req_ready);
    end
  endtask

  task automatic test_single();
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 5'd3;
    bus.req_data[0]  = 32'h0000_0011;
    #3;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: ready=%b expected 01", bus.req_ready);
    end
    tick();
    checks++;
    if (wr_ena !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h0000_0011) begin
      failures++;
      $display("FAIL single_wr: ena=%b addr=%0d data=%h expected 1 3 00000011", wr_ena, wr_addr, wr_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_drop();
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1]  = 5'd0;
    bus.req_data[1]  = 32'hFFFF_FFFF;
    #3;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      failures++;
      $display("FAIL x0_ready: ready=%b expected 10", bus.req_ready);
    end
    tick();
    checks++;
    if (wr_ena !== 1'b0) begin
      failures++;
      $display("FAIL x0_wr: wr_ena=%b expected 0", wr_ena);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    xlen_t d0;
    xlen_t d1;
    xlen_t exp_d;
    d0 = 32'hA000_0000;
    d1 = 32'hB000_0000;
    bus.req_valid   = 2'b11;
    bus.req_addr[0] = 5'd10;
    bus.req_addr[1] = 5'd11;
    bus.req_data[0] = d0;
    bus.req_data[1] = d1;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (bus.req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL contention_ready[%0d]: ready=%b expected %b", i, bus.req_ready,
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      exp_d = (i % 2 == 0) ? d0 : d1;
      tick();
      checks++;
      if (wr_ena !== 1'b1 || wr_data !== exp_d || wr_addr !== ((i % 2 == 0) ? 5'd10 : 5'd11)) begin
        failures++;
        $display("FAIL contention_wr[%0d]: ena=%b addr=%0d data=%h expected data=%h", i,
                 wr_ena, wr_addr, wr_data, exp_d);
      end
      if (i % 2 == 0) begin
        d0 = d0 + 32'd1;
        bus.req_data[0] = d0;
      end else begin
        d1 = d1 + 32'd1;
        bus.req_data[1] = d1;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    check_mask("sb_rsv7", 32'h0000_0080);
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 5'd7;
    bus.req_data[0]  = 32'h0000_0077;
    tick();
    check_mask("sb_rsv_and_commit7", 32'h0000_0080);
    rsv_valid       = 1'b0;
    bus.req_data[0] = 32'h0000_0078;
    tick();
    check_mask("sb_commit7", 32'h0000_0000);
    bus.req_valid = '0;
    rsv_valid     = 1'b1;
    rsv_addr      = 5'd7;
    tick();
    check_mask("sb_rsv7_again", 32'h0000_0080);
    rsv_addr = 5'd0;
    tick();
    check_mask("sb_rsv0", 32'h0000_0080);
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    for (int r = 4; r < 8; r++) begin
      rsv_valid = 1'b1;
      rsv_addr  = reg_addr_t'(r);
      tick();
    end
    check_mask("flush_pre", 32'h0000_00F0);
    flush            = 1'b1;
    rsv_addr         = 5'd9;
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 5'd12;
    bus.req_data[0]  = 32'h1234_5678;
    tick();
    check_mask("flush_mask", 32'h0000_0000);
    checks++;
    if (wr_ena !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL flush_wr: ena=%b addr=%0d data=%h expected 1 12 12345678", wr_ena, wr_addr, wr_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd6;
    tick();
    rsv_valid        = 1'b0;
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 5'd5;
    bus.req_data[0]  = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (wr_ena !== 1'b1 || wr_data !== 32'hDEAD_BEEF || pending_mask !== 32'h0000_0040) begin
      failures++;
      $display("FAIL midwr_pre: ena=%b data=%h mask=%h expected 1 deadbeef 00000040", wr_ena, wr_data, pending_mask);
    end
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (wr_ena !== 1'b0 || pending_mask !== 32'd0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      failures++;
      $display("FAIL midwr_rst: ena=%b mask=%h addr=%0d data=%h expected all 0", wr_ena, pending_mask, wr_addr, wr_data);
    end
    tick();
    tick();
    rst = 1'b0;
    // Pointer was 1 before reset; after reset requester 0 must win.
    bus.req_valid   = 2'b11;
    bus.req_addr[0] = 5'd20;
    bus.req_addr[1] = 5'd21;
    bus.req_data[0] = 32'h0000_0020;
    bus.req_data[1] = 32'h0000_0021;
    #3;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL ptr_after_rst: ready=%b expected 01", bus.req_ready);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    tick();
    test_single();
    test_x0_drop();
    test_contention();
    test_scoreboard();
    test_flush();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
